// File: rtl/wbit_sync_fifo.sv
// wbit_sync_fifo: single-clock first-word-fall-through FIFO.
// Head entry is always on read_data; full/empty come from the registered pointers.
//
// Ports:
//   clk_i      in  1           clock, rising edge
//   rst_ni     in  1           asynchronous active-low reset
//   write_en   in  1           push request
//   read_en    in  1           pop request
//   write_data in  DATA_WIDTH  data pushed on an accepted write
//   read_data  out DATA_WIDTH  current head entry (combinational from storage)
//   full       out 1           FIFO holds FIFO_DEPTH entries
//   empty      out 1           FIFO holds no entries
module wbit_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     wr_idx, rd_idx;
    logic                  wr_acc, rd_acc;

    assign wr_idx = wr_ptr_q[ADDR_W-1:0];
    assign rd_idx = rd_ptr_q[ADDR_W-1:0];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // even though both have equal index bits.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) &&
                   (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

    // Acceptance uses the pre-edge flags, so a push into a full FIFO is
    // dropped even if a pop happens in the same cycle, and vice versa.
    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    assign read_data = mem_q[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so read_data is a defined 0 afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_idx] <= write_data;
        end
    end

endmodule

// File: tb/tb_wbit_sync_fifo.sv
// tb_wbit_sync_fifo: directed bench for wbit_sync_fifo.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wbit_sync_fifo;

    logic       clk_i;
    logic       rst_ni;
    logic       write_en;
    logic       read_en;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       full;
    logic       empty;

    int n_vec;
    int n_err;

    wbit_sync_fifo #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .write_en  (write_en),
        .read_en   (read_en),
        .write_data(write_data),
        .read_data (read_data),
        .full      (full),
        .empty     (empty)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of requests, then idle the inputs after the edge.
    task automatic step(input logic we, input logic re, input logic [7:0] wd);
        write_en   = we;
        read_en    = re;
        write_data = wd;
        @(posedge clk_i);
        #1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = 8'h00;
    endtask

    task automatic flags(input string tag, input logic e, input logic f);
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
        check({tag, ".full"}, {31'd0, full}, {31'd0, f});
    endtask

    // Pop one entry, checking the head value seen before the pop edge.
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, read_data}, {24'd0, exp});
        step(1'b0, 1'b1, 8'h00);
    endtask

    logic [7:0] b;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_ni     = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = 8'h00;
        b          = 8'h00;

        // Reset state
        @(posedge clk_i);
        #1;
        flags("rst", 1'b1, 1'b0);
        check("rst.rdata", {24'd0, read_data}, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i * 8'h11));
            if (i == 7) flags("fill7", 1'b0, 1'b0);
        end
        flags("fill8", 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hFF);
        flags("ovf", 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            pop_chk("drain", 8'(i * 8'h11));
            if (i == 1) flags("drain1", 1'b0, 1'b0);
        end
        flags("drained", 1'b1, 1'b0);

        // FWFT
        step(1'b1, 1'b0, 8'hA5);
        check("fwft.rdata", {24'd0, read_data}, 32'hA5);
        flags("fwft", 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        flags("fwft.pop", 1'b1, 1'b0);

        // Underflow
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            flags("udf", 1'b1, 1'b0);
        end
        step(1'b1, 1'b0, 8'h3C);
        check("udf.rdata", {24'd0, read_data}, 32'h3C);
        flags("udf.wr", 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        flags("udf.pop", 1'b1, 1'b0);

        // Simultaneous on empty: only the write lands
        step(1'b1, 1'b1, 8'h5A);
        check("sim0.rdata", {24'd0, read_data}, 32'h5A);
        flags("sim0", 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        flags("sim0.cnt1", 1'b1, 1'b0);

        // Simultaneous at count 4
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
        check("sim4.head", {24'd0, read_data}, 32'h01);
        step(1'b1, 1'b1, 8'h05);
        flags("sim4", 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) pop_chk("sim4.ord", 8'(i));
        flags("sim4.cnt", 1'b1, 1'b0);

        // Simultaneous on full: read taken, write dropped
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        flags("simf.pre", 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hEE);
        check("simf.rdata", {24'd0, read_data}, 32'hC1);
        flags("simf", 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hD0);
        flags("simf.cnt7", 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) pop_chk("simf.ord", 8'(8'hC0 + i));
        pop_chk("simf.last", 8'hD0);
        flags("simf.done", 1'b1, 1'b0);

        // Wrap-around with interleaved bursts of 5
        b = 8'h40;
        for (int it = 0; it < 20; it++) begin
            step(1'b1, 1'b0, b);
            pop_chk("wrap.single", b);
            flags("wrap.single", 1'b1, 1'b0);
            b = b + 8'd1;
            if (it % 4 == 3) begin
                for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(b + k));
                flags("wrap.burst", 1'b0, 1'b0);
                for (int k = 0; k < 5; k++) pop_chk("wrap.burst", 8'(b + k));
                flags("wrap.drain", 1'b1, 1'b0);
                b = b + 8'd5;
            end
        end

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b0, 8'h78);
        step(1'b1, 1'b0, 8'h79);
        check("ares.pre", {24'd0, read_data}, 32'h77);
        #2;
        rst_ni = 1'b0;
        #1;
        flags("ares", 1'b1, 1'b0);
        check("ares.rdata", {24'd0, read_data}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        flags("ares.rd", 1'b1, 1'b0);
        check("ares.rd.rdata", {24'd0, read_data}, 32'h0);
        step(1'b1, 1'b0, 8'h99);
        check("ares.wr", {24'd0, read_data}, 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wbit_sync_fifo.md
# wbit_sync_fifo

Single-clock, first-word-fall-through FIFO used as the TX and RX byte buffers of the SPI master peripheral, and usable anywhere a small synchronous queue is needed. Storage is a register array with full/empty flags; the head entry is always visible on `read_data`, so a consumer can sample the data and pop it in the same cycle.

## Interface
- `DATA_WIDTH`, default 8: width of each entry in bits, ≥1.
- `FIFO_DEPTH`, default 8: number of entries; power of two, ≥2.

- `clk_i`  in  1: clock; all state updates on its rising edge.
- `rst_ni`  in  1: reset; one clock, asynchronous and active-low.
- `write_en`  in  1: push request.
- `read_en`  in  1: pop request.
- `write_data`  in  DATA_WIDTH: data pushed when a write is accepted.
- `read_data`  out  DATA_WIDTH: current head entry, combinational from storage.
- `full`  out  1: FIFO holds FIFO_DEPTH entries.
- `empty`  out  1: FIFO holds 0 entries.

## Operation
- State: storage array of FIFO_DEPTH × DATA_WIDTH, write pointer and read pointer of log2(FIFO_DEPTH)+1 bits each. The MSB is the wrap bit and the lower bits are the index.
- `empty` = (wr_ptr == rd_ptr).
- `full` = index bits equal and wrap bits differ.
- Both flags are combinational from the registered pointers.
- Write accepted iff `write_en && !full`. On the clock edge, `write_data` is stored at `mem[wr_ptr index]` and wr_ptr increments.
- Read accepted iff `read_en && !empty`. On the clock edge, rd_ptr increments.
- `read_data` = `mem[rd_ptr index]` at all times (FWFT). The caller samples it in the cycle it asserts `read_en`.
- Write while full: ignored. Storage, pointers and flags are unchanged; no error flag.
- Read while empty: ignored. rd_ptr is unchanged.
- Simultaneous accepted read and write: both take effect and occupancy is unchanged.
- Simultaneous read and write while full: only the read is accepted; the write is dropped (acceptance uses the pre-edge `full`).
- Simultaneous read and write while empty: only the write is accepted; the read is ignored (acceptance uses the pre-edge `empty`).
- Pointers wrap modulo 2·FIFO_DEPTH, so the index wraps modulo FIFO_DEPTH with no special handling.
- Data order is strictly first-in first-out.

## Timing
- Reset (`rst_ni` low, asynchronous): pointers = 0 and all storage entries = 0.
  - Outputs: `empty`=1, `full`=0, `read_data`=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Write-to-visible latency: a word written into an empty FIFO appears on `read_data` and `empty` deasserts in the cycle after the write edge.
- Pop latency: after a read edge, `read_data` shows the next entry in the same following cycle.
- After popping the last entry, `empty`=1 in the following cycle.
  - `read_data` then shows the stale storage entry at rd_ptr; this value is don't-care for consumers.
- `full` asserts in the cycle after the FIFO_DEPTH-th net write.
- `full` deasserts in the cycle after any accepted read.
- No combinational path from `write_en`/`read_en` to `full`/`empty`/`read_data`.

## Test plan
- Reset: hold `rst_ni` low mid-stream with data stored -> `empty`=1, `full`=0 and `read_data`=0 asynchronously; a subsequent read is ignored.
- Fill/drain: write 0x11..0x88 (8 words) -> `full`=1 after the 8th edge. A 9th write of 0xFF is dropped. Reading 8 times returns 0x11..0x88 in order, each value seen on `read_data` before its pop edge. `empty`=1 after the 8th read.
- FWFT: write 0xA5 into an empty FIFO -> next cycle `read_data`=0xA5 and `empty`=0. Assert `read_en` that cycle -> `empty`=1 the following cycle.
- Underflow: assert `read_en` for 3 cycles while empty -> pointers unchanged. Then write 0x3C -> `read_data`=0x3C.
- Simultaneous ops:
  - Empty with write+read of 0x5A -> only the write is accepted; `read_data`=0x5A and count = 1.
  - Count = 4 with write+read -> count stays 4 and order is preserved.
  - Full with write 0xEE + read -> head popped, 0xEE dropped, count = 7.
- Wrap-around: 20 iterations of write-then-read of incrementing bytes, interleaved with bursts of 5 -> all data returned in order; flags correct across pointer wraps.
